inst_queue: RTL and testbench
=============================

Name: inst_queue

Overview:
- Instruction buffer between the instruction-memory stage (insm) and decode.
- Absorbs decode stalls caused by register reservation, so insm/fetch can keep streaming.
- Accepts {pc, inst} beats on a valid/ready slave port and presents them in order on a valid/ready master port.
- Discards all buffered and in-flight beats on a taken jump from execute.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- AW, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-low.
- valid_i  input  1  upstream beat valid.
- ready_o  output  1  queue can accept a beat this cycle.
- pc_i  input  32  upstream pc.
- inst_i  input  32  upstream instruction word.
- valid_ro  output  1  head entry valid, driven from state.
- ready_i  input  1  downstream (decode) accepts the head.
- pc_ro  output  32  head pc.
- inst_ro  output  32  head instruction.
- jump_taken_i  input  1  flush request from execute.
- count_o  output  AW+1  number of occupied entries.

Behaviour:
- Reset (rst=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0.
  - valid_ro=0, pc_ro=0, inst_ro=0, count_o=0, ready_o=1.
  - Storage array contents need not be reset.
  - Releasing reset takes effect on the next clk edge; no beat is accepted while rst=0.
- Storage: DEPTH x 64-bit registers {pc, inst}. Pointers wrap modulo DEPTH by natural AW-bit overflow.
- Push: push = valid_i & ready_o & ~jump_taken_i. On push, write mem[wr_ptr] and increment wr_ptr.
- Pop: pop = valid_ro & ready_i & ~jump_taken_i. On pop, increment rd_ptr.
- Count update: count += push - pop. Simultaneous push and pop leaves count unchanged and moves both pointers.
- ready_o = (count != DEPTH).
  - Depends only on state. No combinational path from ready_i to ready_o.
  - When full, a push is refused even if a pop happens in the same cycle.
- valid_ro = (count != 0).
  - pc_ro/inst_ro = mem[rd_ptr] when valid_ro=1, else 0.
  - No combinational path from any _i data or valid input to any output.
- Latency: a beat pushed at edge N is visible on valid_ro/pc_ro/inst_ro after edge N. Minimum 1 cycle; no empty bypass.
- Ordering: strict FIFO; each accepted beat is presented exactly once.
- Flush (jump_taken_i=1 at an edge):
  - wr_ptr=rd_ptr=0, count=0.
  - The incoming beat in that cycle is dropped, even if valid_i=1 and ready_o=1.
  - The head is not considered consumed.
  - After the edge: valid_ro=0, ready_o=1.
  - Flush overrides push and pop in the same cycle.
  - Consecutive flush cycles keep the queue empty.
- Downstream stall: while valid_ro=1 and ready_i=0, pc_ro/inst_ro hold stable. The head must not change until it is popped or flushed.
- Empty with ready_i=1: no pop occurs and pointers are unchanged.
- Full with valid_i=1: the beat is not accepted; upstream holds it because ready_o=0.
- count_o mirrors count.
- A mid-operation reset discards all contents immediately, identical to the reset state.

Test Plan:
- Reset, then push pc=0x00,0x04,0x08 with ready_i=0 -> count_o=3, valid_ro=1, pc_ro=0x00 held stable; then ready_i=1 -> pops 0x00,0x04,0x08 on consecutive cycles, then valid_ro=0.
- Push 4 beats (pc 0x10..0x1C) with ready_i=0 -> ready_o=0, count_o=4; a fifth beat pc=0x20 held on valid_i is not taken; raise ready_i -> the 0x20 beat is accepted one cycle after the first pop, and order 0x10,0x14,0x18,0x1C,0x20 is preserved.
- Continuous valid_i=1, ready_i=1 streaming of 10 beats (pc 0x100 step 4) -> one beat per cycle, count_o steady at 1, pointers wrap past DEPTH with no loss or duplication.
- Queue holding 0x40,0x44 and jump_taken_i=1 asserted with valid_i=1 (pc=0x48) and ready_i=1 -> next cycle count_o=0, valid_ro=0, ready_o=1; 0x40 is not counted as consumed; 0x48 never appears on the output.
- The beat pc=0x80 pushed in the cycle after a flush -> appears on pc_ro after one edge with count_o=1.
- Assert rst=0 asynchronously mid-stream with count_o=3 -> all outputs go to reset values immediately without waiting for a clk edge; after release the queue is empty and accepts beats.

Source files
------------

// File: rtl/inst_queue.sv
// Instruction buffer between the instruction-memory stage and decode.
// In-order {pc, inst} FIFO with a registered head and a flush from execute.
module inst_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [31:0]   pc_i,
    input  logic [31:0]   inst_i,
    output logic          valid_ro,
    input  logic          ready_i,
    output logic [31:0]   pc_ro,
    output logic [31:0]   inst_ro,
    input  logic          jump_taken_i,
    output logic [AW:0]   count_o
);

    localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

    logic [63:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic          w_push;
    logic          w_pop;
    logic [63:0]   w_head;

    // Handshake outputs are functions of state only, so no input reaches them combinationally.
    assign ready_o  = (r_count != L_FULL);
    assign valid_ro = (r_count != '0);
    assign count_o  = r_count;

    assign w_push = valid_i & ready_o & ~jump_taken_i;
    assign w_pop  = valid_ro & ready_i & ~jump_taken_i;

    assign w_head  = r_mem[r_rd_ptr];
    assign pc_ro   = valid_ro ? w_head[63:32] : '0;
    assign inst_ro = valid_ro ? w_head[31:0]  : '0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {pc_i, inst_i};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (jump_taken_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: driver queues expected beats on acceptance,
// a negedge monitor pops and compares every beat decode takes.
module tb_inst_queue;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] pc_i;
    logic [31:0] inst_i;
    logic        valid_ro;
    logic        ready_i;
    logic [31:0] pc_ro;
    logic [31:0] inst_ro;
    logic        jump_taken_i;
    logic [2:0]  count_o;

    int checks   = 0;
    int failures = 0;
    int pops     = 0;
    logic [63:0] exp_q[$];

    inst_queue #(.DEPTH(4), .AW(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .pc_i         (pc_i),
        .inst_i       (inst_i),
        .valid_ro     (valid_ro),
        .ready_i      (ready_i),
        .pc_ro        (pc_ro),
        .inst_ro      (inst_ro),
        .jump_taken_i (jump_taken_i),
        .count_o      (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_inst(input logic [31:0] pc);
        mk_inst = {pc[15:0], ~pc[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a beat is consumed when decode accepts it without a flush.
    always @(negedge clk) begin
        if (rst && valid_ro && ready_i && !jump_taken_i) begin
            logic [63:0] e;
            checks++;
            pops++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected: got pc 0x%0h expected no beat", pc_ro);
            end else begin
                e = exp_q.pop_front();
                if ({pc_ro, inst_ro} !== e) begin
                    failures++;
                    $display("FAIL pop_data: got pc 0x%0h inst 0x%0h expected pc 0x%0h inst 0x%0h",
                             pc_ro, inst_ro, e[63:32], e[31:0]);
                end
            end
        end
    end

    // One clock cycle of stimulus, entered and left at posedge+1.
    task automatic cyc(input logic v, input logic [31:0] pc, input logic rdy, input logic jmp,
                       output logic acc);
        valid_i      = v;
        pc_i         = pc;
        inst_i       = mk_inst(pc);
        ready_i      = rdy;
        jump_taken_i = jmp;
        @(negedge clk);
        acc = v && ready_o && !jmp;
        if (acc) exp_q.push_back({pc, mk_inst(pc)});
        @(posedge clk);
        #1;
        valid_i      = 1'b0;
        jump_taken_i = 1'b0;
    endtask

    task automatic drain();
        logic a;
        int n;
        n = 0;
        while (count_o != 0 && n < 20) begin
            cyc(1'b0, 32'h0, 1'b1, 1'b0, a);
            n++;
        end
        chk("drain_empty", {29'd0, count_o}, 32'd0);
    endtask

    initial begin
        logic a;
        int tries;
        int pops_before;

        rst = 1'b0; valid_i = 1'b0; pc_i = '0; inst_i = '0; ready_i = 1'b0; jump_taken_i = 1'b0;
        #1;
        chk("rst_valid", {31'd0, valid_ro}, 32'd0);
        chk("rst_ready", {31'd0, ready_o}, 32'd1);
        chk("rst_count", {29'd0, count_o}, 32'd0);
        chk("rst_pc", pc_ro, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Fill three with decode stalled, then drain.
        cyc(1'b1, 32'h00, 1'b0, 1'b0, a);
        chk("lat_valid", {31'd0, valid_ro}, 32'd1);
        chk("lat_count", {29'd0, count_o}, 32'd1);
        cyc(1'b1, 32'h04, 1'b0, 1'b0, a);
        cyc(1'b1, 32'h08, 1'b0, 1'b0, a);
        chk("t1_count", {29'd0, count_o}, 32'd3);
        chk("t1_valid", {31'd0, valid_ro}, 32'd1);
        chk("t1_head", pc_ro, 32'h00);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, a);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, a);
        chk("t1_head_stable", pc_ro, 32'h00);
        repeat (3) cyc(1'b0, 32'h0, 1'b1, 1'b0, a);
        chk("t1_empty_valid", {31'd0, valid_ro}, 32'd0);
        chk("t1_pops", pops, 3);

        // Full queue refuses a fifth beat until a slot frees.
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h10 + 32'(4*i), 1'b0, 1'b0, a);
        chk("t2_full_ready", {31'd0, ready_o}, 32'd0);
        chk("t2_full_count", {29'd0, count_o}, 32'd4);
        cyc(1'b1, 32'h20, 1'b0, 1'b0, a);
        chk("t2_refused", {31'd0, a}, 32'd0);
        chk("t2_still_full", {29'd0, count_o}, 32'd4);
        tries = 0;
        a = 1'b0;
        while (!a && tries < 8) begin
            cyc(1'b1, 32'h20, 1'b1, 1'b0, a);
            tries++;
            if (tries == 1) chk("t2_after_pop_count", {29'd0, count_o}, 32'd3);
        end
        chk("t2_accept_cycle", tries, 2);
        chk("t2_pushpop_count", {29'd0, count_o}, 32'd3);
        drain();
        chk("t2_pops", pops, 8);

        // Streaming with both sides ready; pointers wrap past DEPTH.
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 32'h100 + 32'(4*i), 1'b1, 1'b0, a);
            chk("t3_stream_count", {29'd0, count_o}, 32'd1);
        end
        drain();
        chk("t3_pops", pops, 18);

        // Flush with a beat arriving and decode ready.
        cyc(1'b1, 32'h40, 1'b0, 1'b0, a);
        cyc(1'b1, 32'h44, 1'b0, 1'b0, a);
        chk("t4_pre_count", {29'd0, count_o}, 32'd2);
        pops_before = pops;
        exp_q.delete();
        cyc(1'b1, 32'h48, 1'b1, 1'b1, a);
        chk("t4_flush_count", {29'd0, count_o}, 32'd0);
        chk("t4_flush_valid", {31'd0, valid_ro}, 32'd0);
        chk("t4_flush_ready", {31'd0, ready_o}, 32'd1);
        chk("t4_no_consume", pops, pops_before);
        cyc(1'b1, 32'h4C, 1'b1, 1'b1, a);
        chk("t4_flush2_count", {29'd0, count_o}, 32'd0);

        // First beat after a flush.
        cyc(1'b1, 32'h80, 1'b0, 1'b0, a);
        chk("t5_count", {29'd0, count_o}, 32'd1);
        chk("t5_head", pc_ro, 32'h80);
        drain();
        chk("t5_pops", pops, 19);

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h300 + 32'(4*i), 1'b0, 1'b0, a);
        chk("t6_pre_count", {29'd0, count_o}, 32'd3);
        #2;
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("t6_async_count", {29'd0, count_o}, 32'd0);
        chk("t6_async_valid", {31'd0, valid_ro}, 32'd0);
        chk("t6_async_ready", {31'd0, ready_o}, 32'd1);
        chk("t6_async_pc", pc_ro, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_release_count", {29'd0, count_o}, 32'd0);
        cyc(1'b1, 32'h200, 1'b0, 1'b0, a);
        chk("t6_new_count", {29'd0, count_o}, 32'd1);
        chk("t6_new_head", pc_ro, 32'h200);
        drain();

        chk("final_pops", pops, 20);
        chk("final_sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
